// File: rtl/microwave_cu_pkg.sv
// Shared encodings for the microwave control unit and its datapath:
// FSM states, datapath button pulse codes, field select codes and status LEDs.
package microwave_cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_UP   = 2'b10;
  localparam logic [1:0] BTN_DOWN = 2'b01;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_SEC  = 2'b01;

  localparam logic [2:0] LED_NONE  = 3'b000;
  localparam logic [2:0] LED_RUN   = 3'b100;
  localparam logic [2:0] LED_PAUSE = 3'b010;
  localparam logic [2:0] LED_DONE  = 3'b001;

  function automatic logic [2:0] led_of(state_t s);
    case (s)
      ST_RUN:   led_of = LED_RUN;
      ST_PAUSE: led_of = LED_PAUSE;
      ST_DONE:  led_of = LED_DONE;
      default:  led_of = LED_NONE;
    endcase
  endfunction

endpackage

// File: rtl/microwave_cu_btn_edge_det.sv
// Rising-edge detector for one debounced button level.
// The previous level resets to 1 so a button held through reset never counts as a press.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/microwave_cu.sv
// Microwave oven control unit: button edge detection, operating-mode FSM and
// buzzer timer. All outputs are registered alongside the state.
//
// state   | meaning
// IDLE    | waiting, no field selected
// SET_MIN | up/down adjust minutes
// SET_SEC | up/down adjust seconds
// RUN     | countdown enabled
// PAUSE   | countdown held (start press or door opened)
// DONE    | buzzer sounding for DONE_CYC cycles
module microwave_cu
  import microwave_cu_pkg::*;
#(
  parameter int DONE_CYC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_cancel,
  input  logic       door_open,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       finish,
  output logic [1:0] btn,
  output logic [1:0] sel,
  output logic       run,
  output logic       buzzer,
  output logic [2:0] state_led
);

  localparam int CW = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;

  logic [4:0] level, press;
  logic       p_mode, p_up, p_down, p_start, p_cancel;

  assign level = {btn_mode, btn_up, btn_down, btn_start, btn_cancel};
  assign {p_mode, p_up, p_down, p_start, p_cancel} = press;

  for (genvar i = 0; i < 5; i++) begin : g_edge
    btn_edge_det u_edge (
      .clk   (clk),
      .rst   (rst),
      .level (level[i]),
      .press (press[i])
    );
  end

  state_t        state, state_nxt;
  logic [1:0]    btn_nxt;
  logic [CW-1:0] done_cnt;
  logic          can_run, done_tc;

  assign can_run = !door_open && ({min, sec} != 12'd0);
  assign done_tc = (done_cnt == CW'(DONE_CYC - 1));

  // Priority: cancel > finish > door_open > start > mode > up/down
  always_comb begin
    state_nxt = state;
    btn_nxt   = BTN_NONE;
    if (p_cancel) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_SET_MIN, ST_SET_SEC: begin
          if (p_start) begin
            if (can_run) state_nxt = ST_RUN;
          end else if (p_mode) begin
            case (state)
              ST_IDLE:    state_nxt = ST_SET_MIN;
              ST_SET_MIN: state_nxt = ST_SET_SEC;
              default:    state_nxt = ST_IDLE;
            endcase
          end else if (state != ST_IDLE && (p_up ^ p_down)) begin
            btn_nxt = p_up ? BTN_UP : BTN_DOWN;
          end
        end
        ST_RUN: begin
          if (finish)                    state_nxt = ST_DONE;
          else if (door_open || p_start) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (p_start && can_run) state_nxt = ST_RUN;
        end
        ST_DONE: begin
          if ((|press) || done_tc) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      btn       <= BTN_NONE;
      sel       <= SEL_NONE;
      run       <= 1'b0;
      buzzer    <= 1'b0;
      state_led <= LED_NONE;
      done_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      btn       <= btn_nxt;
      sel       <= (state_nxt == ST_SET_MIN) ? SEL_MIN :
                   (state_nxt == ST_SET_SEC) ? SEL_SEC : SEL_NONE;
      run       <= (state_nxt == ST_RUN);
      buzzer    <= (state_nxt == ST_DONE);
      state_led <= led_of(state_nxt);
      if (state != ST_DONE)      done_cnt <= '0;
      else if (!done_tc)         done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule
